// File: rtl/dmem_responder.sv
// Wait-state data memory for the MIPS32 MEM stage: serves one load/store per WAIT_CYCLES+2 cycles.
// Optional macro DMEM_ALIGN_CHECK_EN adds the align_err pulse and suppresses misaligned accesses.
//
// state  | meaning
// S_IDLE | no access in flight; a request is latched here
// S_WAIT | counting wait states; the access commits on the edge leaving this state
// S_DONE | response cycle, resp_valid high; always returns to S_IDLE
`timescale 1ns/1ps
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        resp_valid,
  output logic        stall
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic        align_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               mis_q, mis_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               resp_q, resp_d;
  logic               aerr_q, aerr_d;
  logic [31:0]        mem_q [DEPTH_WORDS];

  logic               req;
  logic               addr_mis;
  logic               commit;
  logic               c_wr;
  logic               c_mis;
  logic [IDX_W-1:0]   c_idx;
  logic [31:0]        c_wdata;
  logic               mem_we;

  logic               unused_addr;
  assign unused_addr = ^{addr[31:IDX_W+2], addr[1:0]};

  assign req      = mem_read | mem_write;
  assign addr_mis = ALIGN_CHK && (addr[1:0] != 2'b00);
  // stall depends only on state and the request strobes
  assign stall    = ((state_q == S_IDLE) && req) || (state_q == S_WAIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;
    rdata_d = rdata_q;
    resp_d  = 1'b0;
    aerr_d  = 1'b0;
    commit  = 1'b0;
    c_wr    = wr_q;
    c_mis   = mis_q;
    c_idx   = idx_q;
    c_wdata = wdata_q;
    mem_we  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          wr_d    = mem_write;
          idx_d   = addr[IDX_W+1:2];
          wdata_d = write_data;
          mis_d   = addr_mis;
          cnt_d   = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            // zero wait states: commit straight from the request inputs
            state_d = S_DONE;
            commit  = 1'b1;
            c_wr    = mem_write;
            c_mis   = addr_mis;
            c_idx   = addr[IDX_W+1:2];
            c_wdata = write_data;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_DONE;
          commit  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      resp_d = 1'b1;
      aerr_d = c_mis;
      if (!c_mis) begin
        if (c_wr) mem_we = 1'b1;
        else      rdata_d = mem_q[c_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      mis_q   <= 1'b0;
      rdata_q <= 32'd0;
      resp_q  <= 1'b0;
      aerr_q  <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      aerr_q  <= aerr_d;
      if (mem_we) mem_q[c_idx] <= c_wdata;
    end
  end

  assign read_data  = rdata_q;
  assign resp_valid = resp_q;

`ifdef DMEM_ALIGN_CHECK_EN
  assign align_err = aerr_q;
`else
  logic unused_aerr;
  assign unused_aerr = aerr_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (default parameters).
// Align-check vectors are compiled in when DMEM_ALIGN_CHECK_EN is defined.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int WAIT_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        resp_valid;
  logic        stall;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        align_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .resp_valid (resp_valid),
    .stall      (stall)
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    .align_err  (align_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one request at a negedge, hold it until the response cycle, then drop it.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_aerr);
    int  n_stall;
    bit  seen;
    n_stall = 0;
    seen    = 1'b0;
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; write_data = d;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
      if (stall) n_stall++;
      @(negedge clk);
    end
    chk({tag, "_resp_seen"}, 32'(seen), 32'd1);
    chk({tag, "_stall_cycles"}, 32'(n_stall), 32'(WAIT_CYCLES + 1));
    chk({tag, "_stall_in_done"}, 32'(stall), 32'd0);
    chk({tag, "_rdata"}, read_data, exp_rd);
`ifdef DMEM_ALIGN_CHECK_EN
    chk({tag, "_align_err"}, 32'(align_err), 32'(exp_aerr));
`else
    if (exp_aerr) chk({tag, "_align_err_unexpected"}, 32'(exp_aerr), 32'd0);
`endif
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    int n_resp;
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = 32'd0; write_data = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    chk("rst_rdata", read_data, 32'd0);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("rst_aerr", 32'(align_err), 32'd0);
`endif

    access("ld40", 1, 0, 32'h40, 32'h0, 32'h0, 0);
    access("st10", 0, 1, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    access("ld10", 1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);

    access("st400", 0, 1, 32'h400, 32'h12345678, 32'hDEADBEEF, 0);
    access("ld000", 1, 0, 32'h000, 32'h0, 32'h12345678, 0);

    access("st30", 0, 1, 32'h30, 32'h11, 32'h12345678, 0);
    access("ld30", 1, 0, 32'h30, 32'h0, 32'h11, 0);
    access("rdwr8", 1, 1, 32'h8, 32'hA5A5A5A5, 32'h11, 0);
    access("ld8", 1, 0, 32'h8, 32'h0, 32'hA5A5A5A5, 0);

    // Store aborted by reset during the second wait cycle
    @(negedge clk);
    mem_write = 1'b1; addr = 32'h20; write_data = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; mem_write = 1'b0;
    #1;
    chk("abort_resp_now", 32'(resp_valid), 32'd0);
    chk("abort_rdata_cleared", read_data, 32'd0);
    n_resp = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (resp_valid) n_resp++;
    end
    chk("abort_resp_count", 32'(n_resp), 32'd0);
    access("ld20_after_rst", 1, 0, 32'h20, 32'h0, 32'h0, 0);
    access("ld10_after_rst", 1, 0, 32'h10, 32'h0, 32'h0, 0);

`ifdef DMEM_ALIGN_CHECK_EN
    access("st20", 0, 1, 32'h20, 32'h55, 32'h0, 0);
    access("ld20", 1, 0, 32'h20, 32'h0, 32'h55, 0);
    access("st22_mis", 0, 1, 32'h22, 32'hFFFFFFFF, 32'h55, 1);
    access("ld40_clr", 1, 0, 32'h40, 32'h0, 32'h0, 0);
    access("ld20_kept", 1, 0, 32'h20, 32'h0, 32'h55, 0);
    access("ld21_mis", 1, 0, 32'h21, 32'h0, 32'h55, 1);
`else
    access("st13_trunc", 0, 1, 32'h13, 32'h77, 32'h0, 0);
    access("ld10_trunc", 1, 0, 32'h10, 32'h0, 32'h77, 0);
    access("ld12_trunc", 1, 0, 32'h12, 32'h0, 32'h77, 0);
`endif

    @(negedge clk);
    #1;
    chk("idle_stall", 32'(stall), 32'd0);
    chk("idle_resp", 32'(resp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Wait-state data-memory responder for the pipelined MIPS32 core. It serves the MEM-stage request from the EX/MEM register as a load or a store. While an access is in flight it drives `stall` back to the pipeline so the EX/MEM and MEM/WB registers hold. It sits between the EX/MEM buffer and the MEM/WB buffer and replaces the zero-latency data memory.

## Interface
Parameters:
- `DEPTH_WORDS`, default 256: number of 32-bit words. Power of two, at least 2.
- `WAIT_CYCLES`, default 2: extra cycles between request acceptance and response. Range 0–15.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `mem_read`, input, 1: load request from EX/MEM. Level-held while stalled.
- `mem_write`, input, 1: store request from EX/MEM. Level-held while stalled.
- `addr`, input, 32: byte address (EX/MEM ALU result).
- `write_data`, input, 32: store data (EX/MEM forwarded rt value).
- `read_data`, output, 32: load result, registered.
- `resp_valid`, output, 1: one-cycle pulse; the access has completed this cycle.
- `stall`, output, 1: combinational; hold EX/MEM and MEM/WB this cycle.
- `align_err`, output, 1: only when `DMEM_ALIGN_CHECK_EN` is defined. Registered one-cycle pulse.

## Operation
- Storage is an array of `DEPTH_WORDS` × 32 bits.
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo the depth.
- A request is any cycle with `mem_read | mem_write` while the FSM is in IDLE.
- If `mem_read` and `mem_write` are both high, the access is a store only. `read_data` is unchanged.
- FSM states and transitions:
  - IDLE: no request → stay in IDLE with `stall=0`. Request → `stall=1`; latch op, index and `write_data`; load the counter with `WAIT_CYCLES`. Next state is WAIT, or DONE if `WAIT_CYCLES==0`.
  - WAIT: `stall=1`; the counter decrements each cycle. When the counter is 1, the next state is DONE, and on that edge the access commits:
    - a store writes the latched data to the array;
    - a load captures the array word into `read_data`.
  - DONE: `stall=0`, `resp_valid=1`. The pipeline advances on this edge. Next state is IDLE.
- Request inputs are ignored in WAIT and DONE; only the latched copy is used.
- `read_data` holds its last load value until the next load commits.

## Timing
- Reset values: state IDLE, counter 0, `read_data=0`, `resp_valid=0`, `align_err=0`, `stall=0`. Every array word is cleared to 0.
- Request presented in IDLE at cycle t:
  - `stall` is high for cycles t through t+WAIT_CYCLES;
  - `resp_valid` and load data are valid at cycle t+WAIT_CYCLES+1;
  - the next request can be accepted at t+WAIT_CYCLES+2.
- A store is visible to a load accepted in any later cycle.
- Back-to-back requests: the DONE→IDLE bubble is mandatory. Throughput is one access per WAIT_CYCLES+2 cycles.
- Reset asserted mid-access: abort to IDLE. A store not yet committed is dropped. No `resp_valid` is issued.
- `stall` is combinational from the FSM state and the `mem_read`/`mem_write` inputs only. There is no path from `addr` or `write_data` to `stall`.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - A request with `addr[1:0]!=2'b00` still runs through the full WAIT/DONE sequence.
  - A store does not modify the array; a load leaves `read_data` unchanged.
  - `align_err` pulses together with `resp_valid`.
- `DMEM_ALIGN_CHECK_EN` undefined:
  - The `align_err` port does not exist.
  - `addr[1:0]` is ignored and misaligned accesses use the truncated word index.

## Test plan
- Reset, then a load from 0x40 → `stall` high for 3 cycles, then `resp_valid` pulses with `read_data=0x00000000`.
- Store 0xDEADBEEF to 0x10, then load 0x10 → the load's `resp_valid` cycle shows 0xDEADBEEF. Each access takes 4 cycles (default WAIT_CYCLES=2), with `stall` low between them.
- `DEPTH_WORDS=256`: store 0x12345678 to 0x400, then load 0x000 → returns 0x12345678 (wrap-around).
- `mem_read=mem_write=1`, `write_data=0xA5A5A5A5`, addr 0x8, with `read_data` previously 0x11 → the store commits and `read_data` stays 0x11. A later load of 0x8 returns 0xA5A5A5A5.
- Store 0xCAFEF00D to 0x20, with `reset` pulsed in the second WAIT cycle → no `resp_valid`. A load of 0x20 after reset returns 0.
- With `DMEM_ALIGN_CHECK_EN`: store 0xFFFFFFFF to 0x22 → `align_err` and `resp_valid` pulse together. A load of 0x20 returns its prior value.
